mux_data_arb: RTL and testbench
===============================

// Module: mux_data_arb
// PURPOSE
//  Parametrised N-channel data-bus selector with request/grant arbitration and a registered output.
//  Sources (write-init, write-format, init, write-RTC, ...) raise req. The block grants one source,
//  latches its byte and holds it stable until the bus FSM signals done.
//  Sits between the per-operation data generators and the RTC bus-drive FSM.
//  Includes a watchdog that releases a stuck grant.
// PARAMETERS
//  DW      8    data width per channel
//  NCH     4    number of source channels (>=2); ch0=WI, ch1=WF, ch2=I, ch3=WR by convention
//  SELW    2    index width, = $clog2(NCH)
//  TMO     255  watchdog limit in clk cycles while in HOLD (>=2)
// PORTS
//  clk        in   1        system clock, rising edge
//  reset      in   1        asynchronous reset, active-low (0 = reset)
//  req        in   NCH      per-channel request, level, held until granted transaction ends
//  data_in    in   NCH*DW   channel k data at [k*DW +: DW]
//  done       in   1        1-cycle pulse from bus FSM: current transfer finished
//  grant      out  NCH      one-hot grant, registered
//  sel        out  SELW     index of granted channel, registered
//  data_out   out  DW       latched data of granted channel
//  data_valid out  1        data_out valid (=|grant)
//  abort      out  1        1-cycle pulse: granted req dropped before done
//  timeout    out  1        1-cycle pulse: watchdog expired
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; grant=0, sel=0, data_out=0, data_valid=0,
//    abort=0, timeout=0, watchdog=0, rr pointer=0.
//  - FSM IDLE -> HOLD -> REL -> IDLE.
//  - IDLE: if |req, pick winner w; next edge: grant=1<<w, sel=w, data_out=data_in[w], data_valid=1,
//    watchdog=0 -> HOLD. Latency req->grant = 1 cycle. No req: stay, outputs 0.
//  - HOLD: data_out frozen (later data_in changes ignored); watchdog++ each cycle.
//    Exit priority, highest first:
//    (1) done=1 -> REL (normal, even if req[w] fell the same cycle);
//    (2) req[w]=0 -> REL, abort pulses 1 cycle;
//    (3) watchdog==TMO-1 -> REL, timeout pulses 1 cycle.
//  - REL: grant=0, data_valid=0, data_out holds last value, sel holds -> IDLE next edge.
//    Requests are not sampled here; minimum 3 cycles between successive grants.
//  - done in IDLE/REL ignored. At most one grant bit ever set. abort/timeout never coincide.
//  - Reset mid-HOLD: immediate return to reset values; no abort/timeout pulse.
//  - Arithmetic: watchdog width $clog2(TMO+1), saturates, never wraps.
// CONFIGURATION
//  MUX_DATA_RR_EN defined: round-robin arbitration. Search starts at (last_granted+1) mod NCH,
//    wraps past NCH-1 to 0. Pointer updates only on entry to HOLD.
//  MUX_DATA_RR_EN undefined: fixed priority, lowest index wins; no pointer register.
// STRUCTURE
//  Package mux_data_pkg: state encoding (IDLE=2'd0, HOLD=2'd1, REL=2'd2), default DW/NCH/TMO,
//    channel index constants CH_WI=0, CH_WF=1, CH_I=2, CH_WR=3.
//  Sub-module arb_prio_pick: combinational picker (req, start index) -> one-hot + index + any.
//    Fixed mode ties start to 0. All registers stay in mux_data_arb.
// TESTING
//  1 reset=0 mid-stream -> all outputs 0 immediately; release, req=0 for 5 cycles -> grant stays 0.
//  2 req=4'b0100, data_in ch2=8'hA5 -> next cycle grant=0100, sel=2, data_out=A5, data_valid=1;
//    change ch2 to 8'h3C -> data_out stays A5; done pulse -> REL, then IDLE.
//  3 fixed mode, req=4'b1010 held -> grant ch1; after done, ch1 is regranted
//    (ch3 starves until req[1] falls).
//  4 MUX_DATA_RR_EN, req=4'b1111 held, done every 4th cycle -> grant order 0,1,2,3,0;
//    after last grant 3, req=4'b0001 -> 0.
//  5 grant ch0, drop req[0] with no done -> abort=1 one cycle, grant=0; done+drop same cycle -> no abort.
//  6 TMO=8, grant held, no done -> timeout=1 on 8th HOLD cycle, grant=0 next edge,
//    regrant after 3 cycles if req still high.

Source files
------------

// File: rtl/mux_data_pkg.sv
// mux_data_pkg: shared constants for the mux_data_arb data-bus selector.
//   - FSM state encoding (ST_IDLE / ST_HOLD / ST_REL)
//   - default data width, channel count and watchdog limit
//   - conventional channel indices for the RTC data generators
package mux_data_pkg;

  localparam int DEF_DW  = 8;
  localparam int DEF_NCH = 4;
  localparam int DEF_TMO = 255;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;

  localparam int CH_WI = 0;  // write-init
  localparam int CH_WF = 1;  // write-format
  localparam int CH_I  = 2;  // init
  localparam int CH_WR = 3;  // write-RTC

endpackage

// File: rtl/arb_prio_pick.sv
// arb_prio_pick: combinational priority picker.
//   Searches req starting at index 'start', wrapping past NCH-1 to 0, and
//   returns the first set channel.
// Ports:
//   req      in   NCH   request vector
//   start    in   SELW  first index to examine
//   gnt_oh   out  NCH   one-hot winner (0 when no request)
//   gnt_idx  out  SELW  winner index (0 when no request)
//   any      out  1     at least one request present
module arb_prio_pick
  import mux_data_pkg::*;
#(
  parameter int NCH  = DEF_NCH,
  parameter int SELW = $clog2(DEF_NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] start,
  output logic [NCH-1:0]  gnt_oh,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!any && req[(int'(start) + i) % NCH]) begin
        any     = 1'b1;
        gnt_idx = SELW'((int'(start) + i) % NCH);
        gnt_oh[(int'(start) + i) % NCH] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_data_arb.sv
// mux_data_arb: N-channel data-bus selector between the per-operation data
// generators and the RTC bus-drive FSM. Grants one requesting source, latches
// its byte and holds it until the bus FSM reports done. A watchdog releases a
// grant that is held too long.
// Build option: define MUX_DATA_RR_EN for round-robin arbitration; otherwise
// fixed priority (lowest index wins).
// Ports:
//   clk         in   1       system clock
//   reset       in   1       async reset, active-low
//   req         in   NCH     per-channel request level
//   data_in     in   NCH*DW  channel k data at [k*DW +: DW]
//   done        in   1       transfer-finished pulse from bus FSM
//   grant       out  NCH     one-hot registered grant
//   sel         out  SELW    index of granted channel
//   data_out    out  DW      latched data of granted channel
//   data_valid  out  1       |grant
//   abort       out  1       pulse: granted req dropped before done
//   timeout     out  1       pulse: watchdog expired
//
// state   | meaning
// IDLE    | no grant, sampling requests
// HOLD    | grant active, data frozen, watchdog running
// REL     | grant dropped, one dead cycle before sampling again
module mux_data_arb
  import mux_data_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int NCH  = DEF_NCH,
  parameter int SELW = $clog2(NCH),
  parameter int TMO  = DEF_TMO
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*DW-1:0] data_in,
  input  logic              done,
  output logic [NCH-1:0]    grant,
  output logic [SELW-1:0]   sel,
  output logic [DW-1:0]     data_out,
  output logic              data_valid,
  output logic              abort,
  output logic              timeout
);

  localparam int WDW = $clog2(TMO + 1);

  logic [1:0]      state;
  logic [WDW-1:0]  wd;
  logic [NCH-1:0]  pick_oh;
  logic [SELW-1:0] pick_idx;
  logic [SELW-1:0] pick_start;
  logic            pick_any;
  logic [DW-1:0]   pick_data;

`ifdef MUX_DATA_RR_EN
  // rr_ptr holds the index where the next search begins.
  logic [SELW-1:0] rr_ptr;
  assign pick_start = rr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (state == ST_IDLE && pick_any) begin
      rr_ptr <= (pick_idx == SELW'(NCH - 1)) ? '0 : pick_idx + 1'b1;
    end
  end
`else
  assign pick_start = '0;
`endif

  arb_prio_pick #(.NCH(NCH), .SELW(SELW)) u_pick (
    .req     (req),
    .start   (pick_start),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    pick_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (pick_oh[k]) pick_data = data_in[k*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      grant    <= '0;
      sel      <= '0;
      data_out <= '0;
      abort    <= 1'b0;
      timeout  <= 1'b0;
      wd       <= '0;
    end else begin
      abort   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state    <= ST_HOLD;
            grant    <= pick_oh;
            sel      <= pick_idx;
            data_out <= pick_data;
            wd       <= '0;
          end
        end
        ST_HOLD: begin
          if (wd != WDW'(TMO)) wd <= wd + 1'b1;
          // done wins over a simultaneous request drop: the transfer completed.
          if (done) begin
            state <= ST_REL;
            grant <= '0;
          end else if (!req[sel]) begin
            state <= ST_REL;
            grant <= '0;
            abort <= 1'b1;
          end else if (wd == WDW'(TMO - 1)) begin
            state   <= ST_REL;
            grant   <= '0;
            timeout <= 1'b1;
          end
        end
        ST_REL:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign data_valid = |grant;

endmodule

// File: tb/tb_mux_data_arb.sv
// tb_mux_data_arb: directed scenarios plus randomized traffic for
// mux_data_arb (NCH=4, DW=8, TMO=8), checked every cycle against a
// transaction-level model of the grant/hold/release rules.
module tb_mux_data_arb;

  localparam int DW   = 8;
  localparam int NCH  = 4;
  localparam int SELW = 2;
  localparam int TMO  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    req;
  logic [NCH*DW-1:0] data_in;
  logic              done;
  logic [NCH-1:0]    grant;
  logic [SELW-1:0]   sel;
  logic [DW-1:0]     data_out;
  logic              data_valid;
  logic              abort;
  logic              timeout;

  mux_data_arb #(.DW(DW), .NCH(NCH), .SELW(SELW), .TMO(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .data_in    (data_in),
    .done       (done),
    .grant      (grant),
    .sel        (sel),
    .data_out   (data_out),
    .data_valid (data_valid),
    .abort      (abort),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: who owns the bus, how long it has held, and the dead-cycle gap.
  int          m_owner;
  int          m_cnt;
  int          m_gap;
  int          m_sel;
  int          m_ptr;
  logic [7:0]  m_data;
  bit          m_abort;
  bit          m_timeout;

  task automatic m_reset();
    m_owner = -1; m_cnt = 0; m_gap = 0; m_sel = 0; m_ptr = 0;
    m_data = '0; m_abort = 0; m_timeout = 0;
  endtask

  function automatic int m_pick(input logic [NCH-1:0] r);
    int start;
`ifdef MUX_DATA_RR_EN
    start = m_ptr;
`else
    start = 0;
`endif
    for (int i = 0; i < NCH; i++)
      if (r[(start + i) % NCH]) return (start + i) % NCH;
    return -1;
  endfunction

  task automatic m_step();
    int w;
    m_abort = 0;
    m_timeout = 0;
    if (m_owner >= 0) begin
      m_cnt++;
      if (done) begin
        m_owner = -1; m_gap = 1;
      end else if (!req[m_owner]) begin
        m_owner = -1; m_gap = 1; m_abort = 1;
      end else if (m_cnt >= TMO) begin
        m_owner = -1; m_gap = 1; m_timeout = 1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      w = m_pick(req);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_cnt = 0;
        m_data  = data_in[w*DW +: DW];
        m_ptr   = (w + 1) % NCH;
      end
    end
  endtask

  task automatic check_outs(input string tag);
    logic [NCH-1:0] eg;
    eg = (m_owner >= 0) ? NCH'(1 << m_owner) : '0;
    chk({tag, "_grant"}, 32'(grant), 32'(eg));
    chk({tag, "_sel"}, 32'(sel), 32'(m_sel));
    chk({tag, "_data"}, 32'(data_out), 32'(m_data));
    chk({tag, "_valid"}, 32'(data_valid), 32'(m_owner >= 0));
    chk({tag, "_abort"}, 32'(abort), 32'(m_abort));
    chk({tag, "_timeout"}, 32'(timeout), 32'(m_timeout));
  endtask

  // Drive inputs (just after a falling edge), clock once, check at next fall.
  task automatic cyc(input logic [NCH-1:0] r, input logic [NCH*DW-1:0] d, input logic dn,
                     input string tag);
    req = r; data_in = d; done = dn;
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_outs(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, '0, 1'b0, "idle");
  endtask

  initial begin
    int k;
    int nseen;
    int order [5];
    int exp_order [5];
    logic [NCH-1:0] prev_grant;
    logic [NCH-1:0] rq;

    reset = 1'b0; req = '0; data_in = '0; done = 1'b0;
    m_reset();
    #12;
    check_outs("reset");
    @(negedge clk);
    reset = 1'b1;

    // 1: grant in progress, then reset mid-HOLD clears everything at once.
    cyc(4'b0001, 32'h0000_0077, 1'b0, "t1a");
    cyc(4'b0001, 32'h0000_0077, 1'b0, "t1b");
    #2 reset = 1'b0;
    #1 m_reset();
    check_outs("t1_rst");
    @(negedge clk);
    reset = 1'b1;
    idle(5);
    chk("t1_idle_grant", 32'(grant), 32'h0);

    // 2: latch ch2, ignore later data changes, release on done.
    cyc(4'b0100, 32'h00A5_0000, 1'b0, "t2a");
    chk("t2_grant", 32'(grant), 32'h4);
    chk("t2_sel", 32'(sel), 32'h2);
    chk("t2_data", 32'(data_out), 32'hA5);
    cyc(4'b0100, 32'h003C_0000, 1'b0, "t2b");
    chk("t2_frozen", 32'(data_out), 32'hA5);
    cyc(4'b0100, 32'h003C_0000, 1'b1, "t2c");
    chk("t2_rel_grant", 32'(grant), 32'h0);
    idle(3);

`ifndef MUX_DATA_RR_EN
    // 3: fixed priority, ch3 starves while ch1 keeps requesting.
    nseen = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(4'b1010, 32'h4433_2211, 1'(m_owner >= 0), "t3");
      if (grant[3]) nseen++;
    end
    chk("t3_starve", 32'(nseen), 32'h0);
    for (int i = 0; i < 6; i++) begin
      cyc(4'b1000, 32'h4433_2211, 1'b0, "t3b");
      if (grant[3]) nseen++;
    end
    chk("t3_ch3_after_drop", 32'(nseen > 0), 32'h1);
    cyc(4'b1000, 32'h4433_2211, 1'b1, "t3c");
    idle(3);
`else
    // 4: round robin over all four channels.
    exp_order = '{0, 1, 2, 3, 0};
    order = '{-1, -1, -1, -1, -1};
    nseen = 0;
    prev_grant = '0;
    for (int i = 0; i < 40 && nseen < 5; i++) begin
      cyc(4'b1111, 32'h4433_2211, 1'(i % 4 == 3), "t4");
      if (grant != 0 && prev_grant == 0) begin
        order[nseen] = int'(sel);
        nseen++;
      end
      prev_grant = grant;
    end
    for (int i = 0; i < 5; i++) chk("t4_order", 32'(order[i]), 32'(exp_order[i]));
    for (int i = 0; i < 8; i++) cyc(4'b0001, 32'h4433_2211, 1'(m_owner >= 0), "t4b");
    idle(3);
`endif

    // 5: abort on request drop; no abort when done arrives the same cycle.
    cyc(4'b0001, 32'h0000_0055, 1'b0, "t5a");
    cyc(4'b0000, 32'h0000_0055, 1'b0, "t5b");
    chk("t5_abort", 32'(abort), 32'h1);
    chk("t5_abort_grant", 32'(grant), 32'h0);
    idle(2);
    cyc(4'b0001, 32'h0000_0055, 1'b0, "t5c");
    cyc(4'b0000, 32'h0000_0055, 1'b1, "t5d");
    chk("t5_no_abort", 32'(abort), 32'h0);
    idle(2);

    // 6: watchdog expiry after TMO hold cycles, then regrant.
    cyc(4'b0001, 32'h0000_0099, 1'b0, "t6a");
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(4'b0001, 32'h0000_0099, 1'b0, "t6b");
      if (timeout) begin
        k = i;
        break;
      end
    end
    chk("t6_tmo_cycle", 32'(k), 32'(TMO));
    chk("t6_tmo_grant", 32'(grant), 32'h0);
    cyc(4'b0001, 32'h0000_0099, 1'b0, "t6c");
    cyc(4'b0001, 32'h0000_0099, 1'b0, "t6d");
    chk("t6_regrant", 32'(grant), 32'h1);
    cyc(4'b0001, 32'h0000_0099, 1'b1, "t6e");
    idle(2);

    // Randomized traffic: sticky requests, random data, occasional done.
    rq = '0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3) == 0) rq = NCH'($urandom);
      cyc(rq, {$urandom}, 1'($urandom_range(3) == 0), "rnd");
      chk("rnd_onehot", 32'($onehot0(grant)), 32'h1);
      chk("rnd_excl", 32'(abort & timeout), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
